// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - opcode enum and helpers shared by the compare/select pipeline
package cmp_pkg;

  typedef enum logic [2:0] {
    CMP_SLT  = 3'd0,
    CMP_SLTU = 3'd1,
    CMP_EQ   = 3'd2,
    CMP_NE   = 3'd3,
    CMP_MIN  = 3'd4,
    CMP_MAX  = 3'd5,
    CMP_MINU = 3'd6,
    CMP_MAXU = 3'd7
  } cmp_op_e;

  // Boolean ops return the zero-extended predicate; the rest return an operand.
  function automatic logic is_bool_op(input cmp_op_e op);
    return (op inside {CMP_SLT, CMP_SLTU, CMP_EQ, CMP_NE});
  endfunction

endpackage

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational compare/select datapath between the two stages
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  cmp_op_e            op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               flag_o,
  output logic [WIDTH-1:0]   result_o
);

  logic lt_u;
  logic lt_s;
  logic eq;

  always_comb begin
    lt_u = (a_i < b_i);
    // Differing sign bits decide the signed order; otherwise magnitude does.
    lt_s = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? a_i[WIDTH-1] : lt_u;
    eq   = (a_i == b_i);
  end

  always_comb begin
    flag_o = lt_s;
    unique case (op_i)
      CMP_SLT:             flag_o = lt_s;
      CMP_SLTU:            flag_o = lt_u;
      CMP_EQ:              flag_o = eq;
      CMP_NE:              flag_o = !eq;
      CMP_MIN, CMP_MAX:    flag_o = lt_s;
      CMP_MINU, CMP_MAXU:  flag_o = lt_u;
      default:             flag_o = lt_s;
    endcase
  end

  always_comb begin
    result_o = {{(WIDTH-1){1'b0}}, flag_o};
    if (!is_bool_op(op_i)) begin
      if (op_i == CMP_MIN || op_i == CMP_MINU) begin
        result_o = (flag_o || eq) ? a_i : b_i;
      end else begin
        result_o = flag_o ? b_i : a_i;
      end
    end
  end

endmodule

// File: rtl/cmp_pipe_unit.sv
// rtl/cmp_pipe_unit.sv - two-stage compare/select unit with valid/ready backpressure
module cmp_pipe_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_flag,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  issued_cnt
);

  logic              s1_valid_q, s1_valid_d;
  cmp_op_e           s1_op_q,    s1_op_d;
  logic [WIDTH-1:0]  s1_a_q,     s1_a_d;
  logic [WIDTH-1:0]  s1_b_q,     s1_b_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

  logic              s2_valid_q,  s2_valid_d;
  logic [WIDTH-1:0]  s2_result_q, s2_result_d;
  logic              s2_flag_q,   s2_flag_d;
  logic [TAG_W-1:0]  s2_tag_q,    s2_tag_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              advance;
  logic              core_flag;
  logic [WIDTH-1:0]  core_result;

  // One global enable: the whole pipe moves whenever the output slot frees up.
  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (s1_op_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .flag_o   (core_flag),
    .result_o (core_result)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flag_d   = s2_flag_q;
    s2_tag_d    = s2_tag_q;
    cnt_d       = cnt_q;

    if (advance) begin
      // Valid bits depend only on in_valid so unknown operands never leak into them.
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d  = cmp_op_e'(in_op);
        s1_a_d   = in_a;
        s1_b_d   = in_b;
        s1_tag_d = in_tag;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = core_result;
        s2_flag_d   = core_flag;
        s2_tag_d    = s1_tag_q;
      end
    end

    if (s2_valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= CMP_SLT;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flag_q   <= 1'b0;
      s2_tag_q    <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flag_q   <= s2_flag_d;
      s2_tag_q    <= s2_tag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_flag   = s2_flag_q;
  assign out_tag    = s2_tag_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// tb/tb_cmp_pipe_unit.sv - scoreboard bench for cmp_pipe_unit with a behavioural compare model
module tb_cmp_pipe_unit;

  localparam int W = 32;
  localparam int T = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready, in_ready4;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [T-1:0]  in_tag;
  logic          out_valid, out_valid4;
  logic          out_ready;
  logic [W-1:0]  out_result, out_result4;
  logic          out_flag, out_flag4;
  logic [T-1:0]  out_tag, out_tag4;
  logic [15:0]   issued_cnt;
  logic [3:0]    issued_cnt4;

  cmp_pipe_unit #(.WIDTH(W), .TAG_W(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flag(out_flag), .out_tag(out_tag), .issued_cnt(issued_cnt)
  );

  cmp_pipe_unit #(.WIDTH(W), .TAG_W(T), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_flag(out_flag4), .out_tag(out_tag4), .issued_cnt(issued_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         flag;
    logic [T-1:0] tag;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_ret = 0;
  bit   ready_mode = 1'b0;
  bit   ready_val = 1'b1;
  bit   stall_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic f);
    bit lts, ltu;
    lts = ($signed(a) < $signed(b));
    ltu = (a < b);
    case (op)
      3'd0: begin f = lts;       r = W'(lts); end
      3'd1: begin f = ltu;       r = W'(ltu); end
      3'd2: begin f = (a == b);  r = W'(a == b); end
      3'd3: begin f = (a != b);  r = W'(a != b); end
      3'd4: begin f = lts;       r = lts ? a : b; end
      3'd5: begin f = lts;       r = lts ? b : a; end
      3'd6: begin f = ltu;       r = ltu ? a : b; end
      default: begin f = ltu;    r = ltu ? b : a; end
    endcase
  endfunction

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [T-1:0] tag, input bit lat,
                      input bit use_exp, input logic [W-1:0] er, input logic ef);
    exp_t e;
    logic [W-1:0] mr;
    logic mf;
    int waitc;
    model(op, a, b, mr, mf);
    e.res  = use_exp ? er : mr;
    e.flag = use_exp ? ef : mf;
    e.tag  = tag;
    e.lat  = lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    waitc = 0;
    forever begin
      #1;
      if (in_ready) break;
      if (waitc > 200) begin
        chk("send_timeout", 64'(waitc), 64'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waitc++;
    end
    e.acc = cyc;
    sbq.push_back(e);
    n_acc++;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_op = 'x; in_a = 'x; in_b = 'x; in_tag = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_val;
    end
  end

  // Monitor: pops expected results at every retire and watches stall stability.
  initial begin
    exp_t e;
    bit held;
    logic [W-1:0] p_res;
    logic p_flag;
    logic [T-1:0] p_tag;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_res", 64'(out_result), 64'(p_res));
          chk("stall_flag", 64'(out_flag), 64'(p_flag));
          chk("stall_tag", 64'(out_tag), 64'(p_tag));
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out", 64'(out_tag), 64'hFFFF);
          end else begin
            e = sbq.pop_front();
            chk("result", 64'(out_result), 64'(e.res));
            chk("flag", 64'(out_flag), 64'(e.flag));
            chk("tag", 64'(out_tag), 64'(e.tag));
            if (out_valid4) chk("result_c4", 64'(out_result4), 64'(e.res));
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
            n_ret++;
          end
        end
        held = out_valid && !out_ready;
        p_res = out_result; p_flag = out_flag; p_tag = out_tag;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int n0;
    int m;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_flag", 64'(out_flag), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_cnt", 64'(issued_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed corner cases with hand-computed expectations.
    send(3'd0, 32'hFFFF_FFFF, 32'd1, 4'h1, 1'b1, 1'b1, 32'd1, 1'b1);
    send(3'd1, 32'hFFFF_FFFF, 32'd1, 4'h2, 1'b1, 1'b1, 32'd0, 1'b0);
    send(3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 4'h3, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1);
    send(3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 4'h4, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    send(3'd4, 32'd5, 32'd5, 4'hA, 1'b1, 1'b1, 32'd5, 1'b0);
    idle();
    drain();

    for (int i = 0; i < 8; i++) begin
      send(3'(i), $urandom, $urandom, 4'(i), 1'b1, 1'b0, '0, 1'b0);
    end
    idle();
    drain();

    ready_val = 1'b0;
    repeat (2) @(negedge clk);
    n0 = n_acc;
    stall_done = 1'b0;
    fork
      begin
        send(3'd2, 32'd9, 32'd9, 4'h5, 1'b0, 1'b0, '0, 1'b0);
        send(3'd6, 32'd3, 32'hFFFF_0000, 4'h6, 1'b0, 1'b0, '0, 1'b0);
        send(3'd3, 32'd7, 32'd8, 4'h7, 1'b0, 1'b0, '0, 1'b0);
        idle();
        stall_done = 1'b1;
      end
    join_none
    repeat (5) @(negedge clk);
    #1;
    chk("stall_inflight", 64'(n_acc - n0), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    ready_val = 1'b1;
    m = 0;
    while (!stall_done && m < 300) begin
      @(negedge clk);
      m++;
    end
    chk("stall_release", 64'(stall_done), 64'd1);
    drain();
    chk("cnt_16", 64'(issued_cnt), 64'(n_ret));
    chk("cnt4_sat", 64'(issued_cnt4), 64'd15);

    ready_val = 1'b0;
    send(3'd0, 32'd1, 32'd2, 4'h8, 1'b0, 1'b0, '0, 1'b0);
    send(3'd1, 32'd3, 32'd2, 4'h9, 1'b0, 1'b0, '0, 1'b0);
    idle();
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n_ret = 0;
    #2;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(issued_cnt), 64'd0);
    chk("mid_rst_cnt4", 64'(issued_cnt4), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    ready_val = 1'b1;

    ready_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        2: b = a + 32'(($urandom_range(0, 2)) - 1);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        logic [W-1:0] t;
        t = a; a = b; b = t;
      end
      send(3'($urandom_range(0, 7)), a, b, 4'(i), 1'b0, 1'b0, '0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    ready_mode = 1'b0;
    ready_val = 1'b1;
    drain();
    chk("final_cnt", 64'(issued_cnt), 64'(n_ret));
    chk("final_cnt4", 64'(issued_cnt4), 64'((n_ret > 15) ? 15 : n_ret));
    chk("final_retired", 64'(n_ret >= 20), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
